// File: rtl/pipe_lane_offset_core.sv
// Lane-wise offset stage between the 256-bit pipe-in and pipe-out FIFOs.
// Credit-gated reads feed a fixed-latency pipeline that drains into a FWFT skid buffer.
module pipe_lane_offset_core #(
    parameter logic [31:0] OFFSET      = 32'h0000_0001,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned SKID_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [255:0] in_data,
    input  logic         in_empty,
    input  logic         in_valid,
    output logic         in_read,
    output logic [255:0] out_data,
    output logic         out_write,
    input  logic         out_full,
    output logic         busy,
    output logic [31:0]  word_count,
    output logic         err_seq
);

    localparam int unsigned PtrW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(SKID_DEPTH + PIPE_STAGES + 2) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e               state_q, state_d;
    logic                 run_st;
    logic [PIPE_STAGES:0] issue_q;
    logic [CntW-1:0]      inflight;
    logic [CntW-1:0]      skid_count_q, skid_count_d;
    logic [CntW-1:0]      credit_used;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [255:0]         skid_mem_q [SKID_DEPTH];
    logic [PIPE_STAGES-1:0] stg_v_q;
    logic [255:0]         stg_d_q [PIPE_STAGES];
    logic [255:0]         lane_sum;
    logic                 capture_v;
    logic                 skid_push, skid_pop, skid_empty;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (en) state_d = StRun;
            end
            StRun: begin
                if (!en) state_d = StDrain;
            end
            StDrain: begin
                if (en) begin
                    state_d = StRun;
                end else if ((inflight == '0) && skid_empty) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        run_st = 1'b0;
        busy   = 1'b0;
        unique case (state_q)
            StRun: begin
                run_st = 1'b1;
                busy   = 1'b1;
            end
            StDrain: busy = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Credit-based read issue
    // ------------------------------------------------------------------
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= int'(PIPE_STAGES); i++) begin
            inflight = inflight + CntW'(issue_q[i]);
        end
    end

    // A pop in the current cycle is deliberately not credited back.
    assign credit_used = skid_count_q + inflight;
    assign in_read     = run_st & en & ~in_empty & (credit_used < CntW'(SKID_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q <= '0;
        end else begin
            issue_q <= {issue_q[PIPE_STAGES-1:0], in_read};
        end
    end

    // ------------------------------------------------------------------
    // Lane adder and delay pipeline
    // ------------------------------------------------------------------
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < 8; i++) begin
            lane_sum[32*i +: 32] = in_data[32*i +: 32] + OFFSET;
        end
    end

    // Only a word that was actually requested may enter the pipeline.
    assign capture_v = in_valid & issue_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_v_q <= '0;
            for (int i = 0; i < int'(PIPE_STAGES); i++) begin
                stg_d_q[i] <= '0;
            end
        end else begin
            stg_v_q[0] <= capture_v;
            stg_d_q[0] <= lane_sum;
            for (int i = 1; i < int'(PIPE_STAGES); i++) begin
                stg_v_q[i] <= stg_v_q[i-1];
                stg_d_q[i] <= stg_d_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // FWFT skid buffer
    // ------------------------------------------------------------------
    assign skid_push  = stg_v_q[PIPE_STAGES-1];
    assign skid_empty = (skid_count_q == '0);
    assign out_write  = ~skid_empty & ~out_full;
    assign skid_pop   = out_write;
    assign out_data   = skid_mem_q[rd_ptr_q];

    always_comb begin
        skid_count_d = skid_count_q;
        if (skid_push && !skid_pop) begin
            skid_count_d = skid_count_q + CntW'(1);
        end else if (!skid_push && skid_pop) begin
            skid_count_d = skid_count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                skid_mem_q[i] <= '0;
            end
        end else begin
            skid_count_q <= skid_count_d;
            if (skid_push) begin
                skid_mem_q[wr_ptr_q] <= stg_d_q[PIPE_STAGES-1];
                wr_ptr_q             <= wr_ptr_q + PtrW'(1);
            end
            if (skid_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
            err_seq    <= 1'b0;
        end else begin
            if (out_write) begin
                word_count <= word_count + 32'd1;
            end
            if (in_valid != issue_q[0]) begin
                err_seq <= 1'b1;
            end
        end
    end

    skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(skid_push && !skid_pop && (skid_count_q == CntW'(SKID_DEPTH))));

    no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(out_write && out_full));

endmodule

// File: tb/tb_pipe_lane_offset_core.sv
// Directed bench for pipe_lane_offset_core: input FIFO model, expected-word queue
// filled at stimulus time and drained as out_write words appear.
module tb_pipe_lane_offset_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [255:0] in_data = '0;
    logic         in_empty;
    logic         in_valid;
    logic         in_read;
    logic [255:0] out_data;
    logic         out_write;
    logic         out_full;
    logic         busy;
    logic [31:0]  word_count;
    logic         err_seq;

    always #5 clk = ~clk;

    pipe_lane_offset_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_data    (in_data),
        .in_empty   (in_empty),
        .in_valid   (in_valid),
        .in_read    (in_read),
        .out_data   (out_data),
        .out_write  (out_write),
        .out_full   (out_full),
        .busy       (busy),
        .word_count (word_count),
        .err_seq    (err_seq)
    );

    // Input FIFO model: one-cycle read latency, optional dropped valid.
    logic [255:0] src_mem [0:2047];
    int           wr_idx = 0;
    int           rd_idx = 0;
    int           kill_at = -1;
    logic         in_valid_r = 1'b0;
    logic         flush = 1'b0;

    assign in_empty = (rd_idx >= wr_idx);
    assign in_valid = in_valid_r;

    always @(posedge clk) begin
        if (flush) begin
            rd_idx     <= wr_idx;
            in_valid_r <= 1'b0;
        end else if (in_read && (rd_idx < wr_idx)) begin
            in_data    <= src_mem[rd_idx];
            in_valid_r <= (rd_idx != kill_at);
            rd_idx     <= rd_idx + 1;
        end else begin
            in_valid_r <= 1'b0;
        end
    end

    logic [255:0] exp_q [$];
    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           n_reads = 0;
    int           n_writes = 0;
    int           first_rd = -1;
    int           last_wr = -1;
    logic         busy_at_wr = 1'b0;
    logic [255:0] last_data = '0;
    logic [31:0]  sb_words = '0;

    function automatic logic [255:0] add_lanes(input logic [255:0] w);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = w[32*i +: 32] + 32'h0000_0001;
        return r;
    endfunction

    function automatic logic [255:0] rand_word();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [255:0] w, input bit expect_out);
        src_mem[wr_idx] = w;
        wr_idx++;
        if (expect_out) exp_q.push_back(add_lanes(w));
    endtask

    // Sample mid-cycle, then return just after the next rising edge.
    task automatic tick();
        logic [255:0] e;
        @(negedge clk);
        cyc++;
        check("wr_while_full", 256'(out_write & out_full), '0);
        check("word_count", 256'(word_count), 256'(sb_words));
        if (in_read) begin
            n_reads++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (out_write) begin
            n_writes++;
            last_wr    = cyc;
            busy_at_wr = busy;
            last_data  = out_data;
            check("sb_nonempty", 256'(exp_q.size() != 0), 256'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", out_data, e);
            end
            sb_words = sb_words + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_read"}, 256'(in_read), '0);
        check({tag, "_out_write"}, 256'(out_write), '0);
        check({tag, "_busy"}, 256'(busy), '0);
        check({tag, "_word_count"}, 256'(word_count), '0);
        check({tag, "_err_seq"}, 256'(err_seq), '0);
        check({tag, "_out_data"}, out_data, '0);
    endtask

    task automatic apply_reset();
        exp_q.delete();
        rst_n    = 1'b0;
        en       = 1'b0;
        out_full = 1'b0;
        flush    = 1'b1;
        sb_words = '0;
        tick();
        flush = 1'b0;
        tick();
        rst_n    = 1'b1;
        n_reads  = 0;
        n_writes = 0;
        first_rd = -1;
        kill_at  = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        rst_n    = 1'b0;
        en       = 1'b0;
        out_full = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // T1: single all-ones word wraps to zero, latency 4
        push_word({8{32'hFFFF_FFFF}}, 1'b1);
        en = 1'b1;
        for (int i = 0; i < 20 && n_writes < 1; i++) tick();
        check("t1_writes", 256'(n_writes), 256'd1);
        check("t1_latency", 256'(last_wr - first_rd), 256'd4);
        check("t1_zero_lanes", last_data, '0);
        tick();
        check("t1_word_count", 256'(word_count), 256'd1);

        // T2: 1000-word stream
        apply_reset();
        for (int i = 0; i < 1000; i++) push_word(rand_word(), 1'b1);
        en = 1'b1;
        for (int i = 0; i < 5000 && n_writes < 1000; i++) tick();
        check("t2_writes", 256'(n_writes), 256'd1000);
        check("t2_reads", 256'(n_reads), 256'd1000);
        check("t2_sb_empty", 256'(exp_q.size()), '0);
        tick();
        check("t2_word_count", 256'(word_count), 256'd1000);

        // T3: 50 cycles of backpressure mid-stream
        apply_reset();
        for (int i = 0; i < 20; i++) push_word(rand_word(), 1'b1);
        en = 1'b1;
        repeat (6) tick();
        out_full  = 1'b1;
        wr_before = n_writes;
        repeat (50) tick();
        check("t3_outstanding", 256'(n_reads - n_writes), 256'd4);
        check("t3_no_write_full", 256'(n_writes), 256'(wr_before));
        check("t3_read_stalled", 256'(in_read), '0);
        out_full = 1'b0;
        for (int i = 0; i < 200 && n_writes < 20; i++) tick();
        check("t3_writes", 256'(n_writes), 256'd20);
        check("t3_sb_empty", 256'(exp_q.size()), '0);
        tick();
        check("t3_word_count", 256'(word_count), 256'd20);

        // T4: drop en with three words in flight
        apply_reset();
        for (int i = 0; i < 10; i++) push_word(rand_word(), 1'b1);
        en = 1'b1;
        for (int i = 0; i < 20 && n_reads < 3; i++) tick();
        en = 1'b0;
        check("t4_none_written_yet", 256'(n_writes), '0);
        repeat (20) tick();
        check("t4_no_more_reads", 256'(n_reads), 256'd3);
        check("t4_writes", 256'(n_writes), 256'd3);
        check("t4_busy_at_last_wr", 256'(busy_at_wr), 256'd1);
        check("t4_busy_low", 256'(busy), '0);
        check("t4_unread_left", 256'(exp_q.size()), 256'd7);

        // T5: second word's valid suppressed
        apply_reset();
        check("t5_err_clear", 256'(err_seq), '0);
        kill_at = wr_idx + 1;
        push_word(rand_word(), 1'b1);
        push_word(rand_word(), 1'b0);
        push_word(rand_word(), 1'b1);
        en = 1'b1;
        for (int i = 0; i < 30 && n_writes < 2; i++) tick();
        repeat (5) tick();
        check("t5_reads", 256'(n_reads), 256'd3);
        check("t5_writes", 256'(n_writes), 256'd2);
        check("t5_sb_empty", 256'(exp_q.size()), '0);
        check("t5_err_set", 256'(err_seq), 256'd1);
        repeat (10) tick();
        check("t5_err_sticky", 256'(err_seq), 256'd1);

        // T6: asynchronous reset between edges mid-burst
        apply_reset();
        for (int i = 0; i < 20; i++) push_word(rand_word(), 1'b1);
        en = 1'b1;
        repeat (8) tick();
        check("t6_started", 256'(n_writes > 0), 256'd1);
        #2;
        rst_n    = 1'b0;
        sb_words = '0;
        exp_q.delete();
        #1;
        check_zero("t6_async");
        en    = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        rst_n    = 1'b1;
        n_reads  = 0;
        n_writes = 0;
        repeat (10) tick();
        check("t6_idle_writes", 256'(n_writes), '0);
        check("t6_idle_reads", 256'(n_reads), '0);
        push_word(rand_word(), 1'b1);
        push_word(rand_word(), 1'b1);
        en = 1'b1;
        for (int i = 0; i < 30 && n_writes < 2; i++) tick();
        check("t6_writes", 256'(n_writes), 256'd2);
        tick();
        check("t6_word_count", 256'(word_count), 256'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
